// File: rtl/uart_link_scheduler.sv
// Link scheduler for the shared uart_module: arbitrates urgent and periodic
// TX frames with a minimum write gap, drains/decodes RX frames, runs a watchdog.
module uart_link_scheduler #(
   parameter int TX_PERIOD = 15625,
   parameter int MIN_GAP   = 4096,
   parameter int TIMEOUT   = 10_000_000
) (
   input  logic        basys_clk,
   input  logic        rst_n,
   input  logic        urgent_req,
   input  logic [15:0] urgent_data,
   output logic        urgent_ack,
   output logic        urgent_ovr,
   input  logic        periodic_en,
   input  logic [15:0] periodic_data,
   output logic        write_uart,
   output logic [15:0] write_data,
   input  logic        rx_empty,
   input  logic [15:0] read_data,
   output logic        read_uart,
   output logic        rx_valid,
   output logic [1:0]  rx_tag,
   output logic [13:0] rx_payload,
   output logic        rx_err,
   output logic        link_up,
   output logic        tx_state_dbg,
   output logic [1:0]  rx_state_dbg
);

   localparam int PW = (TX_PERIOD > 1) ? $clog2(TX_PERIOD) : 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] P_LAST = PW'(TX_PERIOD - 1);
   localparam logic [GW-1:0] G_LAST = GW'(MIN_GAP - 2);
   localparam logic [WW-1:0] W_MAX  = WW'(TIMEOUT);

   typedef enum logic {T_IDLE, T_GAP} tx_state_e;
   typedef enum logic [1:0] {R_IDLE, R_DEC, R_WAIT} rx_state_e;

   tx_state_e   tx_q, tx_d;
   rx_state_e   rx_q, rx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [WW-1:0] wd_q, wd_d;
   logic        upend_q, upend_d, ppend_q, ppend_d;
   logic [15:0] udata_q, udata_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
   logic        wr_q, wr_d, ack_q, ack_d, ovr_q, ovr_d;
   logic        rd_q, rd_d, rxv_q, rxv_d, rxe_q, rxe_d, link_q, link_d;
   logic [1:0]  tag_q, tag_d;
   logic [13:0] pay_q, pay_d;
   logic        u_issue, u_direct, wrap;

   always_comb begin
      tx_d     = tx_q;
      gap_d    = gap_q;
      upend_d  = upend_q;
      udata_d  = udata_q;
      ppend_d  = ppend_q;
      wr_d     = 1'b0;
      wdata_d  = wdata_q;
      ack_d    = 1'b0;
      ovr_d    = 1'b0;
      u_issue  = 1'b0;
      wrap     = (pcnt_q == P_LAST);
      pcnt_d   = wrap ? '0 : pcnt_q + 1'b1;
      // An idle link sends a fresh request straight away to hit the t+1 write.
      u_direct = (tx_q == T_IDLE) && !upend_q && urgent_req;
      case (tx_q)
         T_IDLE: begin
            if (upend_q || urgent_req) begin
               wr_d    = 1'b1;
               ack_d   = 1'b1;
               wdata_d = upend_q ? udata_q : urgent_data;
               upend_d = 1'b0;
               u_issue = 1'b1;
               tx_d    = T_GAP;
               gap_d   = '0;
            end else if (ppend_q && periodic_en) begin
               wr_d    = 1'b1;
               wdata_d = periodic_data;
               ppend_d = 1'b0;
               tx_d    = T_GAP;
               gap_d   = '0;
            end
         end
         T_GAP: begin
            if (gap_q == G_LAST) tx_d = T_IDLE;
            else gap_d = gap_q + 1'b1;
         end
         default: tx_d = T_IDLE;
      endcase
      if (urgent_req && !u_direct) begin
         upend_d = 1'b1;
         udata_d = urgent_data;
         ovr_d   = upend_q && !u_issue;
      end
      if (wrap) ppend_d = 1'b1;
      if (!periodic_en) ppend_d = 1'b0;
   end

   always_comb begin
      rx_d   = rx_q;
      rbuf_d = rbuf_q;
      rd_d   = 1'b0;
      rxv_d  = 1'b0;
      rxe_d  = 1'b0;
      tag_d  = tag_q;
      pay_d  = pay_q;
      case (rx_q)
         R_IDLE: begin
            if (!rx_empty) begin
               rd_d   = 1'b1;
               rbuf_d = read_data;
               rx_d   = R_DEC;
            end
         end
         R_DEC: begin
            if (rbuf_q[15:14] == 2'b11) begin
               rxe_d = 1'b1;
            end else begin
               rxv_d = 1'b1;
               tag_d = rbuf_q[15:14];
               pay_d = rbuf_q[13:0];
            end
            rx_d = R_WAIT;
         end
         R_WAIT:  rx_d = R_IDLE;
         default: rx_d = R_IDLE;
      endcase
      // Only good frames keep the link alive; reserved tags are ignored here.
      if (rxv_d) wd_d = '0;
      else if (wd_q != W_MAX) wd_d = wd_q + 1'b1;
      else wd_d = wd_q;
      if (rxv_d) link_d = 1'b1;
      else if (wd_d == W_MAX) link_d = 1'b0;
      else link_d = link_q;
   end

   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q    <= T_IDLE;
         gap_q   <= '0;
         pcnt_q  <= '0;
         upend_q <= 1'b0;
         udata_q <= '0;
         ppend_q <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         ovr_q   <= 1'b0;
         rx_q    <= R_IDLE;
         rbuf_q  <= '0;
         rd_q    <= 1'b0;
         rxv_q   <= 1'b0;
         rxe_q   <= 1'b0;
         tag_q   <= '0;
         pay_q   <= '0;
         wd_q    <= '0;
         link_q  <= 1'b0;
      end else begin
         tx_q    <= tx_d;
         gap_q   <= gap_d;
         pcnt_q  <= pcnt_d;
         upend_q <= upend_d;
         udata_q <= udata_d;
         ppend_q <= ppend_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         ovr_q   <= ovr_d;
         rx_q    <= rx_d;
         rbuf_q  <= rbuf_d;
         rd_q    <= rd_d;
         rxv_q   <= rxv_d;
         rxe_q   <= rxe_d;
         tag_q   <= tag_d;
         pay_q   <= pay_d;
         wd_q    <= wd_d;
         link_q  <= link_d;
      end
   end

   assign write_uart   = wr_q;
   assign write_data   = wdata_q;
   assign urgent_ack   = ack_q;
   assign urgent_ovr   = ovr_q;
   assign read_uart    = rd_q;
   assign rx_valid     = rxv_q;
   assign rx_err       = rxe_q;
   assign rx_tag       = tag_q;
   assign rx_payload   = pay_q;
   assign link_up      = link_q;
   assign tx_state_dbg = tx_q;
   assign rx_state_dbg = rx_q;

endmodule

// File: tb/tb_uart_link_scheduler.sv
// Scoreboard bench for uart_link_scheduler with small timing parameters.
module tb_uart_link_scheduler;
   localparam int TX_PERIOD = 20;
   localparam int MIN_GAP   = 8;
   localparam int TIMEOUT   = 100;

   logic basys_clk = 1'b0;
   logic rst_n = 1'b1;
   logic urgent_req = 1'b0;
   logic [15:0] urgent_data = '0;
   logic periodic_en = 1'b0;
   logic [15:0] periodic_data = '0;
   logic urgent_ack, urgent_ovr, write_uart, read_uart, rx_valid, rx_err, link_up;
   logic [15:0] write_data;
   logic rx_empty;
   logic [15:0] read_data;
   logic [1:0] rx_tag;
   logic [13:0] rx_payload;
   logic tx_state_dbg;
   logic [1:0] rx_state_dbg;

   logic [15:0] rx_mem [8];
   logic [3:0] rx_wr = '0;
   logic [3:0] rx_rd = '0;
   logic force_ne = 1'b0;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int ovr_cnt = 0;
   int write_cnt = 0;
   int last_wr = -1000;
   int last_rd = -1000;
   int rd_log[$];
   int exp_cyc_q[$];
   logic [16:0] exp_q[$];
   logic [17:0] rx_exp_q[$];

   uart_link_scheduler #(.TX_PERIOD(TX_PERIOD), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
      .basys_clk(basys_clk), .rst_n(rst_n),
      .urgent_req(urgent_req), .urgent_data(urgent_data),
      .urgent_ack(urgent_ack), .urgent_ovr(urgent_ovr),
      .periodic_en(periodic_en), .periodic_data(periodic_data),
      .write_uart(write_uart), .write_data(write_data),
      .rx_empty(rx_empty), .read_data(read_data), .read_uart(read_uart),
      .rx_valid(rx_valid), .rx_tag(rx_tag), .rx_payload(rx_payload),
      .rx_err(rx_err), .link_up(link_up),
      .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
   );

   // clock / reset-independent infrastructure
   always #5 basys_clk = ~basys_clk;
   always @(posedge basys_clk) cyc <= cyc + 1;

   // RX FIFO model: pops on the edge where read_uart is high
   assign rx_empty  = (rx_rd == rx_wr) && !force_ne;
   assign read_data = rx_mem[rx_rd[2:0]];
   always @(posedge basys_clk) if (read_uart && rx_rd != rx_wr) rx_rd <= rx_rd + 4'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge basys_clk);
      #1;
   endtask

   task automatic expect_write(input int at, input logic ack, input logic [15:0] d);
      exp_cyc_q.push_back(at);
      exp_q.push_back({ack, d});
   endtask

   task automatic push_rx(input logic [15:0] f);
      rx_mem[rx_wr[2:0]] = f;
      rx_wr = rx_wr + 4'd1;
   endtask

   task automatic drain_tx();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      repeat (MIN_GAP + 2) tick();
   endtask

   task automatic wait_rx_valid(input string name, output int v);
      v = -1;
      for (int i = 0; i < 20 && v < 0; i++) begin
         @(negedge basys_clk);
         if (rx_valid) v = cyc;
      end
      if (v < 0) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {write_uart, write_data, urgent_ack, urgent_ovr, read_uart, rx_valid,
                   rx_tag, rx_payload, rx_err, link_up, tx_state_dbg, rx_state_dbg}, 64'd0);
   endtask

   // scoreboard monitor: TX side
   always @(negedge basys_clk) begin
      if (!rst_n) begin
         last_wr = -1000;
      end else begin
         if (write_uart) begin
            write_cnt++;
            if (cyc - last_wr < MIN_GAP) check("write_spacing", cyc - last_wr, MIN_GAP);
            last_wr = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_write", {urgent_ack, write_data}, 17'h1ffff);
            end else begin
               check("write_frame", {urgent_ack, write_data}, exp_q.pop_front());
               check("write_cycle", cyc, exp_cyc_q.pop_front());
            end
         end else if (urgent_ack) begin
            check("ack_without_write", urgent_ack, 0);
         end
         if (urgent_ovr) ovr_cnt++;
      end
   end

   // scoreboard monitor: RX side
   always @(negedge basys_clk) begin
      if (rst_n) begin
         if (read_uart) begin
            if (cyc - last_rd < 3) check("read_spacing", cyc - last_rd, 3);
            last_rd = cyc;
            rd_log.push_back(cyc);
         end
         if (rx_valid || rx_err) begin
            check("rx_latency", cyc, last_rd + 1);
            if (rx_exp_q.size() == 0) check("unexpected_rx", {rx_valid, rx_err, rx_tag, rx_payload}, 0);
            else check("rx_decode", {rx_valid, rx_err, rx_tag, rx_payload}, rx_exp_q.pop_front());
         end
      end
   end

   initial begin : main
      int t, b, v;
      // 1. reset with activity on the inputs
      #1 rst_n = 1'b0;
      urgent_req = 1'b1;
      urgent_data = 16'h1111;
      force_ne = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge basys_clk);
         check_all_zero("reset_outputs");
         if (i == 6) urgent_data = 16'h4ABC;
      end
      tick();
      rst_n = 1'b1;
      force_ne = 1'b0;
      expect_write(cyc + 1, 1'b1, 16'h4ABC);
      tick();
      urgent_req = 1'b0;
      drain_tx();

      // 2. urgent pacing
      urgent_req = 1'b1; urgent_data = 16'h4000; t = cyc;
      expect_write(t + 1, 1'b1, 16'h4000);
      tick(); urgent_req = 1'b0;
      tick(); tick();
      urgent_req = 1'b1; urgent_data = 16'h8000;
      expect_write(t + 9, 1'b1, 16'h8000);
      tick(); urgent_req = 1'b0;
      drain_tx();

      // 3. overwrite while the gap is running
      b = ovr_cnt;
      urgent_req = 1'b1; urgent_data = 16'h4003; t = cyc;
      expect_write(t + 1, 1'b1, 16'h4003);
      tick(); urgent_data = 16'h4001;
      tick(); urgent_data = 16'h4002;
      expect_write(t + 9, 1'b1, 16'h4002);
      tick(); urgent_req = 1'b0;
      drain_tx();
      check("ovr_count", ovr_cnt - b, 1);

      // 4. arbitration against the periodic wrap
      rst_n = 1'b0;
      periodic_en = 1'b1;
      periodic_data = 16'h4D2A;
      repeat (3) tick();
      rst_n = 1'b1;
      t = cyc;
      repeat (19) tick();
      urgent_req = 1'b1; urgent_data = 16'h8000;
      expect_write(t + 20, 1'b1, 16'h8000);
      expect_write(t + 28, 1'b0, 16'h4D2A);
      tick(); urgent_req = 1'b0;
      while (cyc < t + 30) tick();
      periodic_en = 1'b0;
      check("periodic_pending_left", exp_q.size(), 0);
      b = write_cnt;
      repeat (60) tick();
      check("periodic_disabled_writes", write_cnt - b, 0);

      // 5. RX decode of three queued frames
      b = rd_log.size();
      push_rx(16'h4123);
      push_rx(16'hC000);
      push_rx(16'h0007);
      rx_exp_q.push_back({2'b10, 2'd1, 14'h0123});
      rx_exp_q.push_back({2'b01, 2'd1, 14'h0123});
      rx_exp_q.push_back({2'b10, 2'd0, 14'h0007});
      for (int i = 0; i < 30 && rx_exp_q.size() != 0; i++) tick();
      repeat (4) tick();
      check("rx_queue_drained", rx_exp_q.size(), 0);
      if (rd_log.size() >= b + 3) begin
         check("read_gap_1", rd_log[b + 1] - rd_log[b], 3);
         check("read_gap_2", rd_log[b + 2] - rd_log[b + 1], 3);
      end else begin
         check("read_count", rd_log.size() - b, 3);
      end
      check("rx_hold", {rx_tag, rx_payload}, {2'd0, 14'h0007});

      // 6. watchdog
      push_rx(16'h2055);
      rx_exp_q.push_back({2'b10, 2'd0, 14'h2055});
      wait_rx_valid("wd_first", v);
      check("link_rise", link_up, 1);
      if (v >= 0) begin
         while (cyc < v + 99) @(negedge basys_clk);
         check("link_before_timeout", link_up, 1);
         @(negedge basys_clk);
         check("link_at_timeout", link_up, 0);
      end
      #1 push_rx(16'h1ABC);
      rx_exp_q.push_back({2'b10, 2'd0, 14'h1ABC});
      wait_rx_valid("wd_second", v);
      check("link_reraise", link_up, 1);
      repeat (20) @(negedge basys_clk);
      #2 rst_n = 1'b0;
      #1 check("link_async_reset", link_up, 0);
      check_all_zero("async_reset_outputs");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("tx_queue_empty", exp_q.size(), 0);
      check("rx_queue_empty", rx_exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog_timer
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
